// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions (opcodes, ALU ops, hazard FSM states, stall controls).
package hazard_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_MUL  = 4'h8;
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_MUL  = 2'b01,
        ST_MEMW = 2'b10
    } hz_state_t;
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_bubble;
    } hz_ctrl_t;
    localparam hz_ctrl_t CTRL_RUN  = 7'b1111_000;
    localparam hz_ctrl_t CTRL_HOLD = 7'b0000_000;
    localparam hz_ctrl_t CTRL_MUL  = 7'b0001_001;
    localparam hz_ctrl_t CTRL_LU   = 7'b0011_010;
    localparam hz_ctrl_t CTRL_BR   = 7'b1111_100;
    localparam hz_ctrl_t CTRL_RST  = 7'b0000_111;
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    function automatic logic load_use(input logic memread, input logic [4:0] ex_rt,
                                      input logic [4:0] rs, input logic [4:0] rt);
        return memread && (ex_rt != 5'd0) && (ex_rt == rs || ex_rt == rt);
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signal bundle between the datapath and the hazard controller.
interface hazard_ctrl_if;
    logic [4:0] ID_rs_i;
    logic [4:0] ID_rt_i;
    logic       ID_branch_taken_i;
    logic       EX_memread_i;
    logic [4:0] EX_rt_i;
    logic       EX_mul_i;
    logic       MEM_req_i;
    logic       MEM_ack_i;
    logic       PC_we_o;
    logic       IFID_we_o;
    logic       IDEX_we_o;
    logic       EXMEM_we_o;
    logic       IFID_flush_o;
    logic       IDEX_bubble_o;
    logic       EXMEM_bubble_o;
    logic [1:0] state_o;
    modport master (
        output ID_rs_i, ID_rt_i, ID_branch_taken_i, EX_memread_i, EX_rt_i, EX_mul_i, MEM_req_i, MEM_ack_i,
        input  PC_we_o, IFID_we_o, IDEX_we_o, EXMEM_we_o, IFID_flush_o, IDEX_bubble_o, EXMEM_bubble_o, state_o
    );
    modport slave (
        input  ID_rs_i, ID_rt_i, ID_branch_taken_i, EX_memread_i, EX_rt_i, EX_mul_i, MEM_req_i, MEM_ack_i,
        output PC_we_o, IFID_we_o, IDEX_we_o, EXMEM_we_o, IFID_flush_o, IDEX_bubble_o, EXMEM_bubble_o, state_o
    );
endinterface

// File: rtl/hazard_ctrl_mul_stall_counter.sv
// mul_stall_counter: loadable down-counter timing a multi-cycle MUL; o_last flags the final cycle.
module mul_stall_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_last
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) r_cnt <= 4'd0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
    assign o_last = (r_cnt == 4'd1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller (memory wait, multi-cycle MUL, load-use, branch flush).
// Define MUL_MULTICYCLE_EN to hold EX for MUL_CYCLES cycles on a MUL; otherwise MUL is single-cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ID_rs_i,
    input  logic [4:0] ID_rt_i,
    input  logic       ID_branch_taken_i,
    input  logic       EX_memread_i,
    input  logic [4:0] EX_rt_i,
    input  logic       EX_mul_i,
    input  logic       MEM_req_i,
    input  logic       MEM_ack_i,
    output logic       PC_we_o,
    output logic       IFID_we_o,
    output logic       IDEX_we_o,
    output logic       EXMEM_we_o,
    output logic       IFID_flush_o,
    output logic       IDEX_bubble_o,
    output logic       EXMEM_bubble_o,
    output logic [1:0] state_o
);
    hz_state_t r_state, w_next;
    hz_ctrl_t  w_ctrl;
    logic      w_mem_wait, w_load_use, w_mul_go, w_mul_last;
    assign w_mem_wait = MEM_req_i && !MEM_ack_i;
    assign w_load_use = load_use(EX_memread_i, EX_rt_i, ID_rs_i, ID_rt_i);
`ifdef MUL_MULTICYCLE_EN
    logic r_mul_done, w_mul_load;
    // mul_done blocks the just-finished MUL, still visible in EX for one RUN cycle, from retriggering
    assign w_mul_go   = EX_mul_i && !r_mul_done;
    assign w_mul_load = (r_state == ST_RUN) && !w_mem_wait && w_mul_go;
    mul_stall_counter u_mul_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_mul_load),
        .i_load_val (4'(MUL_CYCLES - 1)),
        .i_dec      (r_state == ST_MUL),
        .o_last     (w_mul_last)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) r_mul_done <= 1'b0;
        else if (r_state == ST_MUL && w_mul_last) r_mul_done <= 1'b1;
        else if (r_state == ST_RUN) r_mul_done <= 1'b0;
    end
`else
    logic w_unused;
    assign w_unused   = EX_mul_i ^ (MUL_CYCLES == 0);
    assign w_mul_go   = 1'b0;
    assign w_mul_last = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_RUN;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_ctrl = CTRL_RUN;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_ctrl = CTRL_HOLD;
                    w_next = ST_MEMW;
                end else if (w_mul_go) begin
                    w_ctrl = CTRL_MUL;
                    w_next = ST_MUL;
                end else if (w_load_use) begin
                    w_ctrl = CTRL_LU;
                end else if (ID_branch_taken_i) begin
                    w_ctrl = CTRL_BR;
                end
            end
            ST_MUL: begin
                if (w_mul_last) w_next = ST_RUN;
                else w_ctrl = CTRL_MUL;
            end
            ST_MEMW: begin
                if (MEM_ack_i || !MEM_req_i) w_next = ST_RUN;
                else w_ctrl = CTRL_HOLD;
            end
            default: w_next = ST_RUN;
        endcase
        if (rst_i) w_ctrl = CTRL_RST;
    end
    assign PC_we_o        = w_ctrl.pc_we;
    assign IFID_we_o      = w_ctrl.ifid_we;
    assign IDEX_we_o      = w_ctrl.idex_we;
    assign EXMEM_we_o     = w_ctrl.exmem_we;
    assign IFID_flush_o   = w_ctrl.ifid_flush;
    assign IDEX_bubble_o  = w_ctrl.idex_bubble;
    assign EXMEM_bubble_o = w_ctrl.exmem_bubble;
    assign state_o        = rst_i ? ST_RUN : r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl; MUL sequences follow MUL_MULTICYCLE_EN.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    // {PC_we, IFID_we, IDEX_we, EXMEM_we, IFID_flush, IDEX_bubble, EXMEM_bubble, state[1:0]}
    localparam logic [8:0] E_RUN    = 9'b1111_000_00;
    localparam logic [8:0] E_RST    = 9'b0000_111_00;
    localparam logic [8:0] E_HOLD   = 9'b0000_000_00;
    localparam logic [8:0] E_MEMW   = 9'b0000_000_10;
    localparam logic [8:0] E_MEMREL = 9'b1111_000_10;
    localparam logic [8:0] E_LU     = 9'b0011_010_00;
    localparam logic [8:0] E_BR     = 9'b1111_100_00;
`ifdef MUL_MULTICYCLE_EN
    localparam logic [8:0] E_MULT   = 9'b0001_001_00;
    localparam logic [8:0] E_MULS   = 9'b0001_001_01;
    localparam logic [8:0] E_MULR   = 9'b1111_000_01;
`endif
    hazard_ctrl_if hif ();
    hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ID_rs_i           (hif.ID_rs_i),
        .ID_rt_i           (hif.ID_rt_i),
        .ID_branch_taken_i (hif.ID_branch_taken_i),
        .EX_memread_i      (hif.EX_memread_i),
        .EX_rt_i           (hif.EX_rt_i),
        .EX_mul_i          (hif.EX_mul_i),
        .MEM_req_i         (hif.MEM_req_i),
        .MEM_ack_i         (hif.MEM_ack_i),
        .PC_we_o           (hif.PC_we_o),
        .IFID_we_o         (hif.IFID_we_o),
        .IDEX_we_o         (hif.IDEX_we_o),
        .EXMEM_we_o        (hif.EXMEM_we_o),
        .IFID_flush_o      (hif.IFID_flush_o),
        .IDEX_bubble_o     (hif.IDEX_bubble_o),
        .EXMEM_bubble_o    (hif.EXMEM_bubble_o),
        .state_o           (hif.state_o)
    );
    always #5 clk = ~clk;
    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the next rising edge.
    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic br,
                        input logic mr, input logic [4:0] ert, input logic mul, input logic req,
                        input logic ack);
        @(negedge clk);
        rst = r;
        hif.ID_rs_i = rs;
        hif.ID_rt_i = rt;
        hif.ID_branch_taken_i = br;
        hif.EX_memread_i = mr;
        hif.EX_rt_i = ert;
        hif.EX_mul_i = mul;
        hif.MEM_req_i = req;
        hif.MEM_ack_i = ack;
        #1;
    endtask
    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {hif.PC_we_o, hif.IFID_we_o, hif.IDEX_we_o, hif.EXMEM_we_o,
               hif.IFID_flush_o, hif.IDEX_bubble_o, hif.EXMEM_bubble_o, hif.state_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0); check("rst_idle", E_RST);
        step(1, 5, 5, 1, 1, 5, 1, 1, 0); check("rst_busy_inputs", E_RST);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); check("run_idle", E_RUN);
        step(0, 5, 3, 0, 1, 5, 0, 0, 0); check("lu_rs", E_LU);
        step(0, 5, 3, 0, 0, 5, 0, 0, 0); check("lu_release", E_RUN);
        step(0, 2, 9, 0, 1, 9, 0, 0, 0); check("lu_rt", E_LU);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0); check("lu_r0_no_stall", E_RUN);
        step(0, 7, 7, 0, 0, 7, 0, 0, 0); check("no_memread", E_RUN);
        step(0, 1, 2, 1, 0, 3, 0, 0, 0); check("branch_flush", E_BR);
        step(0, 4, 1, 1, 1, 4, 0, 0, 0); check("lu_with_branch", E_LU);
        step(0, 4, 1, 1, 0, 4, 0, 0, 0); check("branch_after_lu", E_BR);
`ifdef MUL_MULTICYCLE_EN
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul_trigger", E_MULT);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0); check("mul_defers_mem", E_MULS);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul_stall", E_MULS);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul_release", E_MULR);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul_no_retrigger", E_RUN);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); check("mul_after", E_RUN);
`else
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul_ignored", E_RUN);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul_ignored_2", E_RUN);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 1, 0); check("memw_enter", E_HOLD);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0); check("memw_wait_1", E_MEMW);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0); check("memw_wait_2", E_MEMW);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1); check("memw_ack", E_MEMREL);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); check("memw_back_run", E_RUN);
        step(0, 4, 0, 1, 1, 4, 0, 1, 0); check("mem_over_lu_branch", E_HOLD);
        step(0, 0, 0, 1, 0, 0, 0, 1, 0); check("memw_no_flush", E_MEMW);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0); check("memw_req_drop", E_MEMREL);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0); check("branch_reeval", E_BR);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0); check("memw_enter_2", E_HOLD);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0); check("rst_in_memw", E_RST);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); check("run_after_rst", E_RUN);
`ifdef MUL_MULTICYCLE_EN
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul2_trigger", E_MULT);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul2_stall", E_MULS);
        step(1, 0, 0, 0, 0, 0, 1, 0, 0); check("rst_in_mul", E_RST);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul3_retrigger", E_MULT);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul3_stall_1", E_MULS);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul3_stall_2", E_MULS);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0); check("mul3_release", E_MULR);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0); check("mul3_after", E_RUN);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
